// File: rtl/sat_clause_streamer.sv
// Buffers host clause literals and streams them to a SAT solver, then runs it and captures the result.
// Optional run-phase timeout is compiled in with `define SAT_CLAUSE_STREAMER_TIMEOUT_EN.
module sat_clause_streamer #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic [4:0] wr_lit,
    output logic       wr_ready,
    input  logic       start,
    output logic       load,
    output logic       run,
    output logic [4:0] data,
    input  logic [5:0] x,
    input  logic       sol,
    input  logic       done,
    output logic       busy,
    output logic       res_valid,
    output logic       res_sol,
    output logic [5:0] res_x,
    output logic       res_timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_GAP,
        S_RUN,
        S_RESULT
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [4:0]     mem_q [DEPTH];

    logic           load_q, load_d;
    logic           run_q, run_d;
    logic [4:0]     data_q, data_d;
    logic           busy_q, busy_d;
    logic           wr_ready_q, wr_ready_d;
    logic           res_valid_q, res_valid_d;
    logic           res_sol_q, res_sol_d;
    logic [5:0]     res_x_q, res_x_d;

    logic           lit_ok_c;
    logic           push_c;
    logic           pop_c;

`ifdef SAT_CLAUSE_STREAMER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           res_timeout_q, res_timeout_d;
`endif

    // Only 0 and +/-1..6 are meaningful literals; anything else is silently dropped
    assign lit_ok_c = wr_lit[4] ? (wr_lit >= 5'd26) : (wr_lit <= 5'd6);
    assign push_c   = wr_valid && wr_ready_q && lit_ok_c;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        load_d      = 1'b0;
        run_d       = 1'b0;
        data_d      = 5'd0;
        res_valid_d = 1'b0;
        res_sol_d   = res_sol_q;
        res_x_d     = res_x_q;
        pop_c       = 1'b0;
`ifdef SAT_CLAUSE_STREAMER_TIMEOUT_EN
        tmr_d         = tmr_q;
        res_timeout_d = res_timeout_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && (count_q != '0)) begin
                    state_d = S_STREAM;
                    pop_c   = 1'b1;
                end
            end
            S_STREAM: begin
                if (count_q != '0) begin
                    pop_c = 1'b1;
                end else begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_RUN;
                run_d   = 1'b1;
`ifdef SAT_CLAUSE_STREAMER_TIMEOUT_EN
                tmr_d   = '0;
`endif
            end
            S_RUN: begin
                run_d = 1'b1;
                if (done) begin
                    state_d     = S_RESULT;
                    run_d       = 1'b0;
                    res_valid_d = 1'b1;
                    res_sol_d   = sol;
                    res_x_d     = x;
`ifdef SAT_CLAUSE_STREAMER_TIMEOUT_EN
                    res_timeout_d = 1'b0;
                end else if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d       = S_RESULT;
                    run_d         = 1'b0;
                    res_valid_d   = 1'b1;
                    res_sol_d     = 1'b0;
                    res_x_d       = 6'd0;
                    res_timeout_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + TW'(1);
`endif
                end
            end
            S_RESULT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (pop_c) begin
            load_d   = 1'b1;
            data_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end

        count_d    = count_q + CW'(push_c) - CW'(pop_c);
        busy_d     = (state_d != S_IDLE);
        wr_ready_d = (state_d == S_IDLE) && (count_d != CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            load_q      <= 1'b0;
            run_q       <= 1'b0;
            data_q      <= 5'd0;
            busy_q      <= 1'b0;
            wr_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            res_sol_q   <= 1'b0;
            res_x_q     <= 6'd0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            load_q      <= load_d;
            run_q       <= run_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            wr_ready_q  <= wr_ready_d;
            res_valid_q <= res_valid_d;
            res_sol_q   <= res_sol_d;
            res_x_q     <= res_x_d;
        end
    end

    // Literal storage needs no reset; occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_lit;
        end
    end

`ifdef SAT_CLAUSE_STREAMER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q         <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            tmr_q         <= tmr_d;
            res_timeout_q <= res_timeout_d;
        end
    end
    assign res_timeout = res_timeout_q;
`else
    assign res_timeout = 1'b0;
`endif

    assign wr_ready  = wr_ready_q;
    assign load      = load_q;
    assign run       = run_q;
    assign data      = data_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_sol   = res_sol_q;
    assign res_x     = res_x_q;

endmodule

// File: tb/tb_sat_clause_streamer.sv
// Directed self-checking bench for sat_clause_streamer (DEPTH=16, TIMEOUT_CYC=8).
// Timeout scenario follows SAT_CLAUSE_STREAMER_TIMEOUT_EN when defined.
module tb_sat_clause_streamer;

    localparam int unsigned DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [4:0] wr_lit;
    logic       wr_ready;
    logic       start;
    logic       load;
    logic       run;
    logic [4:0] data;
    logic [5:0] x;
    logic       sol;
    logic       done;
    logic       busy;
    logic       res_valid;
    logic       res_sol;
    logic [5:0] res_x;
    logic       res_timeout;

    int checks = 0;
    int errors = 0;

    sat_clause_streamer #(.DEPTH(DEPTH), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_lit(wr_lit), .wr_ready(wr_ready),
        .start(start), .load(load), .run(run), .data(data), .x(x), .sol(sol), .done(done),
        .busy(busy), .res_valid(res_valid), .res_sol(res_sol), .res_x(res_x),
        .res_timeout(res_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] lit);
        wr_valid = 1'b1;
        wr_lit   = lit;
        tick();
        wr_valid = 1'b0;
    endtask

    function automatic logic [4:0] fill_lit(input int i);
        logic [4:0] mag;
        mag = 5'((i % 6) + 1);
        return (i % 2 == 1) ? 5'(-mag) : mag;
    endfunction

    logic [4:0] exp_seq [5];

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_lit = 5'd0; start = 1'b0;
        x = 6'd0; sol = 1'b0; done = 1'b0;
        tick(); tick();
        // Reset values
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_load", 32'(load), 32'd0);
        chk("rst_run", 32'(run), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_res", 32'({res_valid, res_sol, res_x, res_timeout}), 32'd0);
        rst = 1'b0;
        tick();

        // Basic clause stream: 1,2,0,-1,0
        exp_seq = '{5'd1, 5'd2, 5'd0, 5'h1F, 5'd0};
        for (int i = 0; i < 5; i++) wr(exp_seq[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("s1_load%0d", i), 32'(load), 32'd1);
            chk($sformatf("s1_data%0d", i), 32'(data), 32'(exp_seq[i]));
            chk($sformatf("s1_run%0d", i), 32'(run), 32'd0);
            tick();
        end
        chk("s1_gap", 32'({load, run, data}), 32'd0);
        chk("s1_gap_busy", 32'(busy), 32'd1);
        tick();
        chk("s1_run", 32'({load, run}), 32'b01);
        chk("s1_wr_ready_run", 32'(wr_ready), 32'd0);
        // Start during RUN is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("s1_run_after_start", 32'({load, run, res_valid}), 32'b010);
        done = 1'b1; sol = 1'b1; x = 6'b000010;
        tick();
        done = 1'b0; sol = 1'b0; x = 6'd0;
        chk("s1_res_valid", 32'(res_valid), 32'd1);
        chk("s1_res_sol", 32'(res_sol), 32'd1);
        chk("s1_res_x", 32'(res_x), 32'b000010);
        chk("s1_res_run", 32'(run), 32'd0);
        chk("s1_res_timeout", 32'(res_timeout), 32'd0);
        tick();
        chk("s1_res_valid_pulse", 32'(res_valid), 32'd0);
        chk("s1_busy_after", 32'(busy), 32'd0);
        chk("s1_res_hold", 32'({res_sol, res_x}), 32'b1000010);
        chk("s1_wr_ready_after", 32'(wr_ready), 32'd1);

        // Empty-buffer start is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("empty_start_busy", 32'(busy), 32'd0);
        chk("empty_start_load", 32'(load), 32'd0);

        // Out-of-range literals dropped: buffer stays empty
        wr(5'd9); wr(5'h19); wr(5'h10); wr(5'd7);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_load", 32'(load), 32'd0);

        // Fill past DEPTH with wr_valid held
        wr_valid = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            wr_lit = fill_lit(i);
            if (i == DEPTH - 1) chk("fill_ready_last", 32'(wr_ready), 32'd1);
            tick();
            if (i == DEPTH - 1) chk("fill_full", 32'(wr_ready), 32'd0);
        end
        wr_valid = 1'b0;
        chk("fill_full_hold", 32'(wr_ready), 32'd0);
        // Dropped literal while full changes nothing
        wr(5'd9);
        chk("fill_full_drop", 32'(wr_ready), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("fill_data%0d", i), 32'({load, data}), 32'({1'b1, fill_lit(i)}));
            tick();
        end
        chk("fill_gap", 32'({load, run, data}), 32'd0);
        tick();
        chk("fill_run", 32'(run), 32'd1);
`ifdef SAT_CLAUSE_STREAMER_TIMEOUT_EN
        for (int i = 0; i < 7; i++) tick();
        chk("to_run_8th", 32'({run, res_valid}), 32'b10);
        tick();
        chk("to_res_valid", 32'(res_valid), 32'd1);
        chk("to_res_timeout", 32'(res_timeout), 32'd1);
        chk("to_res_sol_x", 32'({res_sol, res_x}), 32'd0);
        chk("to_run_low", 32'(run), 32'd0);
        tick();
`else
        for (int i = 0; i < 20; i++) tick();
        chk("norun_timeout_run", 32'({run, res_valid}), 32'b10);
        done = 1'b1; sol = 1'b0; x = 6'b101010;
        tick();
        done = 1'b0; x = 6'd0;
        chk("fill_res", 32'({res_valid, res_sol, res_x, res_timeout}), 32'({1'b1, 1'b0, 6'b101010, 1'b0}));
        tick();
`endif
        chk("fill_idle", 32'(busy), 32'd0);

        // Write accepted in the same cycle as start joins the stream
        wr(5'd3); wr(5'h1E); wr(5'd0);
        wr_valid = 1'b1; wr_lit = 5'h1C; start = 1'b1;
        tick();
        wr_valid = 1'b0; start = 1'b0;
        exp_seq = '{5'd3, 5'h1E, 5'd0, 5'h1C, 5'd0};
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cowr_data%0d", i), 32'({load, data}), 32'({1'b1, exp_seq[i]}));
            tick();
        end
        chk("cowr_gap", 32'({load, run}), 32'd0);
        tick();
        done = 1'b1; sol = 1'b1; x = 6'b111111;
        tick();
        done = 1'b0; sol = 1'b0; x = 6'd0;
        chk("cowr_res", 32'({res_valid, res_sol, res_x}), 32'({1'b1, 1'b1, 6'b111111}));
        tick();

        // Reset mid-stream after two loads
        wr(5'd1); wr(5'd2); wr(5'd4); wr(5'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mid_load2", 32'({load, data}), 32'({1'b1, 5'd2}));
        rst = 1'b1;
        #1;
        chk("mid_rst_load", 32'({load, data}), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_res", 32'({res_valid, res_sol, res_x}), 32'd0);
        chk("mid_rst_ready", 32'(wr_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("post_rst_start", 32'({busy, load}), 32'd0);
        tick();
        chk("post_rst_idle", 32'({busy, load, run, res_valid}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sat_clause_streamer.md
SAT_CLAUSE_STREAMER -- requirements
Module: sat_clause_streamer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, literal buffer entries (power of two, 4..32).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1023, run-phase cycle limit (used only under REQ-030).
REQ-003 clk  input  1  single clock, all logic rising-edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_valid  input  1  host literal offered.
REQ-006 wr_lit  input  5  signed literal: +v/-v for variable v=1..6, 0 = clause terminator.
REQ-007 wr_ready  output  1  buffer can accept (not full and state IDLE).
REQ-008 start  input  1  one-cycle pulse: begin streaming buffered problem to solver.
REQ-009 load  output  1  solver literal strobe.
REQ-010 run  output  1  solver run enable.
REQ-011 data  output  5  signed literal to solver.
REQ-012 x  input  6  solver assignment.
REQ-013 sol  input  1  solver satisfiable flag.
REQ-014 done  input  1  solver finished.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 res_valid  output  1  one-cycle result strobe.
REQ-017 res_sol  output  1  captured sol.
REQ-018 res_x  output  6  captured x.
REQ-019 res_timeout  output  1  result caused by timeout (0 when REQ-030 absent).

Function
REQ-020 Write: wr_valid&&wr_ready stores wr_lit in FIFO order; no store when full; literals with |value|>6 (+7..+15, -7..-16) SHALL be dropped, not stored.
REQ-021 States: IDLE, STREAM, GAP, RUN, RESULT.
REQ-022 IDLE->STREAM on start with count>0; start with count==0 ignored; start outside IDLE ignored.
REQ-023 STREAM: one literal per cycle, load=1, data=stored literal, entries in write order, no bubbles; after last entry ->GAP; buffer empty afterwards.
REQ-024 GAP: exactly one cycle load=0, run=0, data=0; ->RUN.
REQ-025 RUN: run=1 held; on first cycle done=1 capture res_sol=sol, res_x=x, ->RESULT; done sampled only in RUN.
REQ-026 RESULT: res_valid=1 for exactly one cycle, run=0, ->IDLE; res_sol/res_x hold until next capture.
REQ-027 Latency: start at cycle T with N entries -> first load at T+1, last load at T+N, run first high at T+N+2; res_valid one cycle after done sampled.
REQ-028 load and run never high in same cycle; data=0 whenever load=0.
REQ-029 wr_valid in same cycle as start: write accepted (IDLE, not full) and included in stream.

Reset
REQ-031 On rst: state IDLE, FIFO empty, load=0, run=0, data=0, busy=0, res_valid=0, res_sol=0, res_x=0, res_timeout=0, wr_ready=1.
REQ-032 rst mid-STREAM or mid-RUN: outputs immediately to reset values, buffered literals discarded, no res_valid.

Configuration
REQ-030 Macro SAT_CLAUSE_STREAMER_TIMEOUT_EN: when defined, cycle counter in RUN; if done not seen after TIMEOUT_CYC cycles in RUN, ->RESULT with res_timeout=1, res_sol=0, res_x=0; when undefined, no counter, RUN waits indefinitely, res_timeout tied 0.

Verification
REQ-033 Write 1,2,0,-1,0 then start; expect load high 5 consecutive cycles with data 1,2,0,-1,0, one gap cycle, then run=1.
REQ-034 In RUN drive done=1, sol=1, x=6'b000010 -> res_valid one cycle later for one cycle, res_sol=1, res_x=000010, busy=0 after.
REQ-035 Write DEPTH+2 literals with wr_valid held -> exactly DEPTH accepted, wr_ready=0 at full; write 9 -> dropped, count unchanged.
REQ-036 Assert rst during STREAM after 2 loads -> load=0, busy=0 same cycle; subsequent start with empty buffer -> no activity.
REQ-037 With SAT_CLAUSE_STREAMER_TIMEOUT_EN, TIMEOUT_CYC=8, done never asserted -> res_valid after 8 RUN cycles, res_timeout=1, res_sol=0.
REQ-038 start pulse during RUN -> ignored; result and state unchanged.
